axi_slv_wr_responder: RTL and testbench
=======================================

// Module: axi_slv_wr_responder
// PURPOSE
//  Bench-side AXI3 slave write responder; consumes the write stream from the master write-data driver.
//  Accepts AW and W beats and checks each burst's beat count, WLAST and WID against its AW.
//  Returns one B response per burst, in AW order.
//  Provides scoreboard counters and a sticky error flag.
// PARAMETERS
//  AXI_ADDR_W      32          address width
//  AXI_ID_W        4           ID width
//  AXI_DATA_W      32          write data width
//  SLV_OSTDREQ_NUM 4           AW and B queue depth; power of 2 only, >=2
//  SLV_ADDR_BASE   32'h0       decode base address
//  SLV_ADDR_MASK   32'h0FFF_FFFF offset bits; hit when (awaddr & ~MASK)==BASE
// PORTS
//  aclk           in   1          clock; all logic on posedge
//  areset         in   1          asynchronous, active-high reset
//  in_awvalid     in   1          AW valid
//  out_awready    out  1          AW ready
//  in_awaddr      in   AXI_ADDR_W AW address
//  in_awlen       in   4          beats-1
//  in_awid        in   AXI_ID_W   AW ID
//  in_wvalid      in   1          W valid
//  out_wready     out  1          W ready
//  in_wlast       in   1          W last
//  in_wid         in   AXI_ID_W   W ID
//  in_wdata       in   AXI_DATA_W W data; counted, not stored
//  in_wstrb       in   AXI_DATA_W/8 W strobe
//  out_bvalid     out  1          B valid
//  in_bready      in   1          B ready
//  out_bid        out  AXI_ID_W   B ID
//  out_bresp      out  2          B response
//  out_beat_total out  32         accepted W beats; wraps at 2^32
//  out_err        out  1          sticky: set by any SLVERR/DECERR; cleared by reset only
// BEHAVIOUR
//  Reset: every output 0; queues empty; beat counter 0; LFSR = 16'hACE1.
//  AW queue
//   - Entry = {id, len, dec_hit}; push on awvalid&&awready.
//   - awready = !aw_full (comb).
//  W acceptance
//   - wready = !aw_empty && !b_full (comb).
//   - W before AW is not accepted: wready stays 0.
//   - Handshake increments beat_cnt and out_beat_total.
//  Burst end
//   - Ends on the first handshake with wlast=1 OR beat_cnt==head.len.
//   - On burst end: pop AW head, push B entry, zero beat_cnt.
//  Response selection, in priority order
//   - DECERR 2'b11 if !dec_hit.
//   - SLVERR 2'b10 if wlast!=(beat_cnt==len), or any beat's wid!=head.id (tracked per burst).
//   - Otherwise OKAY 2'b00.
//   - DECERR or SLVERR sets out_err.
//  B channel
//   - bvalid = !b_empty; bid/bresp come from the B queue head (registered).
//   - Earliest B is the cycle after the final W handshake.
//   - Head is held stable until bready; pops on bvalid&&bready.
//  Queues
//   - Simultaneous push+pop: count unchanged, both pointers advance.
//   - Pointers wrap modulo SLV_OSTDREQ_NUM.
//   - Full queue blocks push; pop from an empty queue is impossible by construction.
//  AW and final W beat in the same cycle with the AW queue empty: W is not accepted that cycle.
//  areset mid-burst: discard all state immediately; no B is issued for in-flight bursts.
// CONFIGURATION
//  SLV_WR_RAND_READY_EN defined
//   - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
//   - awready &= lfsr[0]; wready &= lfsr[1].
//  Undefined: readies are as above; no LFSR is instantiated.
// STRUCTURE
//  Package axi_tb_pkg
//   - resp_e {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
//   - aw_ent_t, b_ent_t, LFSR_SEED.
//  Sub-module tb_sync_fifo #(W,DEPTH): instantiated twice, for the AW queue and the B queue.
// TESTING
//  1. Single burst: AW id=4'h5 len=3 addr=0x100; 4 W beats, wlast on beat 4
//     -> B id=5 resp=OKAY; beat_total=4; err=0.
//  2. Four AWs len=0 ids 1..4; bready=0
//     -> awready low on 5th AW; wready low after 4 bursts; B drains 1,2,3,4 in order.
//  3. AW len=3; wlast on beat 2
//     -> burst ends early with SLVERR; next burst decodes normally; err=1.
//  4. AW addr=0x1000_0000 len=0
//     -> DECERR; beat_total=1.
//  5. AW len=7; areset asserted after beat 3
//     -> all outputs 0 immediately; no B issued; next burst returns OKAY.

Source files
------------

// File: rtl/axi_tb_pkg.sv
// rtl/axi_tb_pkg.sv - shared types and constants for the AXI3 slave write responder
package axi_tb_pkg;

    // Queue entries carry IDs at this fixed width; the top narrows to AXI_ID_W.
    localparam int ID_W_MAX = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [3:0]          len;
        logic                dec_hit;
    } aw_ent_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        resp_e               resp;
    } b_ent_t;

endpackage

// File: rtl/axi_slv_wr_responder_if.sv
// rtl/axi_slv_wr_responder_if.sv - AW/W/B channel bundle between write master and slave responder
interface axi_slv_wr_responder_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
);
    logic                    in_awvalid;
    logic                    out_awready;
    logic [AXI_ADDR_W-1:0]   in_awaddr;
    logic [3:0]              in_awlen;
    logic [AXI_ID_W-1:0]     in_awid;
    logic                    in_wvalid;
    logic                    out_wready;
    logic                    in_wlast;
    logic [AXI_ID_W-1:0]     in_wid;
    logic [AXI_DATA_W-1:0]   in_wdata;
    logic [AXI_DATA_W/8-1:0] in_wstrb;
    logic                    out_bvalid;
    logic                    in_bready;
    logic [AXI_ID_W-1:0]     out_bid;
    logic [1:0]              out_bresp;

    modport master (
        output in_awvalid, in_awaddr, in_awlen, in_awid,
        output in_wvalid, in_wlast, in_wid, in_wdata, in_wstrb,
        output in_bready,
        input  out_awready, out_wready, out_bvalid, out_bid, out_bresp
    );

    modport slave (
        input  in_awvalid, in_awaddr, in_awlen, in_awid,
        input  in_wvalid, in_wlast, in_wid, in_wdata, in_wstrb,
        input  in_bready,
        output out_awready, out_wready, out_bvalid, out_bid, out_bresp
    );
endinterface

// File: rtl/tb_sync_fifo.sv
// rtl/tb_sync_fifo.sv - small synchronous FIFO; DEPTH must be a power of two and at least 2
module tb_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (PW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (PW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/axi_slv_wr_responder.sv
// rtl/axi_slv_wr_responder.sv - AXI3 slave write responder with burst checking and in-order B
// Define SLV_WR_RAND_READY_EN to throttle awready/wready with a 16-bit LFSR.
module axi_slv_wr_responder
    import axi_tb_pkg::*;
#(
    parameter int                    AXI_ADDR_W      = 32,
    parameter int                    AXI_ID_W        = 4,
    parameter int                    AXI_DATA_W      = 32,
    parameter int                    SLV_OSTDREQ_NUM = 4,
    parameter logic [AXI_ADDR_W-1:0] SLV_ADDR_BASE   = '0,
    parameter logic [AXI_ADDR_W-1:0] SLV_ADDR_MASK   = AXI_ADDR_W'(32'h0FFF_FFFF)
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi_slv_wr_responder_if.slave bus,
    output logic [31:0]           out_beat_total,
    output logic                  out_err
);
    aw_ent_t    aw_in;
    aw_ent_t    aw_head;
    logic       aw_full;
    logic       aw_empty;
    logic       aw_push;
    b_ent_t     b_in;
    b_ent_t     b_head;
    logic       b_full;
    logic       b_empty;
    logic       b_pop;
    logic       run;
    logic [3:0] beat_cnt;
    logic       id_err_q;
    logic       rand_aw;
    logic       rand_w;
    logic       aw_rdy;
    logic       w_rdy;
    logic       w_hs;
    logic       last_beat;
    logic       wid_bad;
    logic       len_bad;
    logic       burst_end;
    resp_e      resp;
    logic       unused_ok;

`ifdef SLV_WR_RAND_READY_EN
    logic [15:0] lfsr;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign rand_aw = lfsr[0];
    assign rand_w  = lfsr[1];
`else
    assign rand_aw = 1'b1;
    assign rand_w  = 1'b1;
`endif

    always_comb begin
        // run keeps awready low while reset is held and for the first cycle after.
        aw_rdy    = run && !aw_full && rand_aw;
        w_rdy     = !aw_empty && !b_full && rand_w;
        aw_push   = bus.in_awvalid && aw_rdy;
        w_hs      = bus.in_wvalid && w_rdy;
        last_beat = (beat_cnt == aw_head.len);
        burst_end = w_hs && (bus.in_wlast || last_beat);
        wid_bad   = (bus.in_wid != aw_head.id[AXI_ID_W-1:0]);
        len_bad   = (bus.in_wlast != last_beat);
        if (!aw_head.dec_hit) begin
            resp = DECERR;
        end else if (len_bad || id_err_q || wid_bad) begin
            resp = SLVERR;
        end else begin
            resp = OKAY;
        end
        aw_in.id      = ID_W_MAX'(bus.in_awid);
        aw_in.len     = bus.in_awlen;
        aw_in.dec_hit = ((bus.in_awaddr & ~SLV_ADDR_MASK) == SLV_ADDR_BASE);
        b_in.id       = aw_head.id;
        b_in.resp     = resp;
        b_pop         = !b_empty && bus.in_bready;
    end

    assign bus.out_awready = aw_rdy;
    assign bus.out_wready  = w_rdy;
    assign bus.out_bvalid  = !b_empty;
    assign bus.out_bid     = b_head.id[AXI_ID_W-1:0];
    assign bus.out_bresp   = b_head.resp;
    assign unused_ok       = ^{bus.in_wdata, bus.in_wstrb, aw_head.id, b_head.id};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            run            <= 1'b0;
            beat_cnt       <= '0;
            id_err_q       <= 1'b0;
            out_beat_total <= '0;
            out_err        <= 1'b0;
        end else begin
            run <= 1'b1;
            if (w_hs) begin
                out_beat_total <= out_beat_total + 32'd1;
                if (burst_end) begin
                    beat_cnt <= '0;
                    id_err_q <= 1'b0;
                    if (resp != OKAY) begin
                        out_err <= 1'b1;
                    end
                end else begin
                    beat_cnt <= beat_cnt + 4'd1;
                    if (wid_bad) begin
                        id_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    tb_sync_fifo #(.W($bits(aw_ent_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_aw_q (
        .aclk   (aclk),
        .areset (areset),
        .push   (aw_push),
        .din    (aw_in),
        .pop    (burst_end),
        .dout   (aw_head),
        .full   (aw_full),
        .empty  (aw_empty)
    );

    tb_sync_fifo #(.W($bits(b_ent_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_b_q (
        .aclk   (aclk),
        .areset (areset),
        .push   (burst_end),
        .din    (b_in),
        .pop    (b_pop),
        .dout   (b_head),
        .full   (b_full),
        .empty  (b_empty)
    );
endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// tb/tb_axi_slv_wr_responder.sv - directed and randomized bench for axi_slv_wr_responder
module tb_axi_slv_wr_responder;

    logic        aclk;
    logic        areset;
    logic [31:0] beat_total;
    logic        err;

    axi_slv_wr_responder_if #(.AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32)) bus ();

    axi_slv_wr_responder #(
        .AXI_ADDR_W      (32),
        .AXI_ID_W        (4),
        .AXI_DATA_W      (32),
        .SLV_OSTDREQ_NUM (4),
        .SLV_ADDR_BASE   (32'h0),
        .SLV_ADDR_MASK   (32'h0FFF_FFFF)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .bus            (bus),
        .out_beat_total (beat_total),
        .out_err        (err)
    );

    localparam int DEPTH = 4;

    typedef struct {
        int id;
        int len;
        bit hit;
    } aw_m_t;

    typedef struct {
        int id;
        int resp;
    } b_m_t;

    int          errors = 0;
    int          checks = 0;
    aw_m_t       awq[$];
    b_m_t        bq[$];
    int          cur_beats;
    bit          cur_iderr;
    int unsigned m_total;
    bit          m_err;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        awq.delete();
        bq.delete();
        cur_beats = 0;
        cur_iderr = 0;
        m_total   = 0;
        m_err     = 0;
    endtask

    task automatic drive_idle();
        bus.in_awvalid = 1'b0;
        bus.in_awaddr  = '0;
        bus.in_awlen   = '0;
        bus.in_awid    = '0;
        bus.in_wvalid  = 1'b0;
        bus.in_wlast   = 1'b0;
        bus.in_wid     = '0;
        bus.in_wdata   = '0;
        bus.in_wstrb   = '0;
        bus.in_bready  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_awready"}, 32'(bus.out_awready), 0);
        chk({tag, "_wready"}, 32'(bus.out_wready), 0);
        chk({tag, "_bvalid"}, 32'(bus.out_bvalid), 0);
        chk({tag, "_bid"}, 32'(bus.out_bid), 0);
        chk({tag, "_bresp"}, 32'(bus.out_bresp), 0);
        chk({tag, "_total"}, beat_total, 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // Reference: a burst ends at its wlast or its (len+1)th beat, whichever comes first.
    task automatic model_w(input int wid, input bit wlast);
        aw_m_t h;
        b_m_t  b;
        bit    full_len;
        if (awq.size() == 0) begin
            chk("w_accepted_without_aw", 1, 0);
            return;
        end
        h = awq[0];
        cur_beats++;
        m_total++;
        if (wid != h.id) cur_iderr = 1;
        full_len = (cur_beats == h.len + 1);
        if (wlast || full_len) begin
            b.id = h.id;
            if (!h.hit) b.resp = 3;
            else if ((wlast != full_len) || cur_iderr) b.resp = 2;
            else b.resp = 0;
            if (b.resp != 0) m_err = 1;
            bq.push_back(b);
            void'(awq.pop_front());
            cur_beats = 0;
            cur_iderr = 0;
        end
    endtask

    task automatic send_aw(input int id, input int len, input logic [31:0] addr);
        int    n;
        aw_m_t e;
        @(negedge aclk);
        bus.in_awvalid = 1'b1;
        bus.in_awid    = id[3:0];
        bus.in_awlen   = len[3:0];
        bus.in_awaddr  = addr;
        n = 0;
        while (bus.out_awready !== 1'b1 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) begin
            chk("aw_timeout", 0, 1);
        end else begin
            @(posedge aclk);
            e.id  = id;
            e.len = len;
            e.hit = (addr[31:28] == 4'h0);
            awq.push_back(e);
        end
        #1 bus.in_awvalid = 1'b0;
    endtask

    task automatic send_w(input int id, input int len, input int last_at,
                          input int bad_beat, input int max_beats);
        int         nb;
        int         n;
        logic [3:0] idv;
        logic [3:0] w;
        idv = id[3:0];
        nb = ((last_at < len) ? last_at : len) + 1;
        if (nb > max_beats) nb = max_beats;
        for (int i = 0; i < nb; i++) begin
            @(negedge aclk);
            w = (i == bad_beat) ? ~idv : idv;
            bus.in_wvalid = 1'b1;
            bus.in_wid    = w;
            bus.in_wlast  = (i == last_at);
            bus.in_wdata  = $urandom;
            bus.in_wstrb  = 4'hF;
            n = 0;
            while (bus.out_wready !== 1'b1 && n < 100) begin
                @(negedge aclk);
                n++;
            end
            if (n >= 100) begin
                chk("w_timeout", 0, 1);
                break;
            end
            @(posedge aclk);
            model_w(int'(w), (i == last_at));
            #1;
        end
        bus.in_wvalid = 1'b0;
        bus.in_wlast  = 1'b0;
        @(negedge aclk);
        chk("bvalid_after_w", 32'(bus.out_bvalid), 32'(bq.size() != 0));
        chk("beat_total", beat_total, m_total);
        chk("err_flag", 32'(err), 32'(m_err));
    endtask

    task automatic recv_b(input int delay);
        int n;
        @(negedge aclk);
        repeat (delay) @(negedge aclk);
        n = 0;
        while (bus.out_bvalid !== 1'b1 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) begin
            chk("b_timeout", 0, 1);
            return;
        end
        if (bq.size() == 0) begin
            chk("b_unexpected", 1, 0);
        end else begin
            chk("bid", 32'(bus.out_bid), bq[0].id);
            chk("bresp", 32'(bus.out_bresp), bq[0].resp);
        end
        bus.in_bready = 1'b1;
        @(posedge aclk);
        if (bq.size() != 0) void'(bq.pop_front());
        #1 bus.in_bready = 1'b0;
    endtask

    initial begin
        int          id0;
        int          id1;
        int          len0;
        int          len1;
        int          mode;
        logic [31:0] a;

        drive_idle();
        model_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check_all_zero("reset");
        areset = 1'b0;

        // Single clean burst
        send_aw(5, 3, 32'h100);
        send_w(5, 3, 3, -1, 99);
        recv_b(0);
        chk("t1_total", beat_total, 4);
        chk("t1_err", 32'(err), 0);

        // Fill the AW queue, then the B queue with bready held low
        for (int i = 1; i <= 4; i++) send_aw(i, 0, 32'h200 + 32'(i * 16));
        @(negedge aclk);
        chk("t2_awready_full", 32'(bus.out_awready), 32'(awq.size() < DEPTH));
        for (int i = 1; i <= 4; i++) send_w(i, 0, 0, -1, 99);
        send_aw(9, 0, 32'h300);
        @(negedge aclk);
        chk("t2_wready_bfull", 32'(bus.out_wready),
            32'((awq.size() != 0) && (bq.size() < DEPTH)));
        for (int i = 1; i <= 4; i++) recv_b(1);
        send_w(9, 0, 0, -1, 99);
        recv_b(0);

        // AW and its only W beat presented together with the AW queue empty
        @(negedge aclk);
        bus.in_awvalid = 1'b1;
        bus.in_awid    = 4'h7;
        bus.in_awlen   = 4'h0;
        bus.in_awaddr  = 32'h40;
        bus.in_wvalid  = 1'b1;
        bus.in_wid     = 4'h7;
        bus.in_wlast   = 1'b1;
        #1;
        chk("same_cycle_wready", 32'(bus.out_wready), 32'(awq.size() != 0));
        chk("same_cycle_awready", 32'(bus.out_awready), 32'(awq.size() < DEPTH));
        @(posedge aclk);
        awq.push_back('{id: 7, len: 0, hit: 1'b1});
        #1 bus.in_awvalid = 1'b0;
        @(negedge aclk);
        chk("same_cycle_wready_next", 32'(bus.out_wready), 1);
        @(posedge aclk);
        model_w(7, 1'b1);
        #1 bus.in_wvalid = 1'b0;
        bus.in_wlast = 1'b0;
        @(negedge aclk);
        chk("same_cycle_bvalid", 32'(bus.out_bvalid), 32'(bq.size() != 0));
        recv_b(0);

        // Early wlast gives SLVERR; the following burst is unaffected
        send_aw(6, 3, 32'h400);
        send_w(6, 3, 1, -1, 99);
        recv_b(0);
        send_aw(2, 1, 32'h500);
        send_w(2, 1, 1, -1, 99);
        recv_b(0);
        chk("t3_err", 32'(err), 1);

        // Address outside the decoded window
        send_aw(3, 0, 32'h1000_0000);
        send_w(3, 0, 0, -1, 99);
        recv_b(0);

        // Reset in the middle of a burst
        send_aw(8, 7, 32'h600);
        send_w(8, 7, 7, -1, 3);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
        send_aw(10, 2, 32'h700);
        send_w(10, 2, 2, -1, 99);
        recv_b(0);

        // Randomized pairs of outstanding bursts
        for (int k = 0; k < 20; k++) begin
            id0  = $urandom_range(0, 15);
            id1  = $urandom_range(0, 15);
            len0 = $urandom_range(0, 7);
            len1 = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:28] = 4'h0;
            else a[31:28] = 4'($urandom_range(1, 15));
            send_aw(id0, len0, a);
            a = $urandom;
            a[31:28] = 4'h0;
            send_aw(id1, len1, a);
            mode = $urandom_range(0, 3);
            case (mode)
                1:       send_w(id0, len0, $urandom_range(0, len0), -1, 99);
                2:       send_w(id0, len0, len0 + 1, -1, 99);
                3:       send_w(id0, len0, len0, $urandom_range(0, len0), 99);
                default: send_w(id0, len0, len0, -1, 99);
            endcase
            send_w(id1, len1, len1, -1, 99);
            recv_b($urandom_range(0, 3));
            recv_b($urandom_range(0, 3));
        end

        drive_idle();
        repeat (2) @(negedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
